sram_arbiter: RTL and testbench

Shares one dual-port (one read port, one write port) byte-enabled SRAM between `num_requesters` masters. The read and write ports are arbitrated independently with round-robin priority, so one read and one write can be granted per cycle. Read data is routed back to the owning requester one cycle after its grant. It sits between the accelerator's load/store engines and the word-wide SRAM macro.

---
 rtl/sram_arb_pkg.sv | 41 ++++
 rtl/sram_arbiter_rr_arbiter.sv | 61 ++++++
 rtl/sram_arbiter.sv | 112 +++++++++++
 tb/tb_sram_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared types and helpers for the SRAM port arbiter.
//   - MAX_REQUESTERS : upper bound on masters (vectors are padded to this width)
//   - onehot_to_idx  : one-hot grant vector to binary index
//   - rotate_search  : round-robin search starting at a pointer, returns a one-hot grant
package sram_arb_pkg;

   localparam int MAX_REQUESTERS = 16;
   localparam int IDX_W          = 4;

   typedef logic [MAX_REQUESTERS-1:0] req_vec_t;
   typedef logic [IDX_W-1:0]          req_idx_t;

   function automatic req_idx_t onehot_to_idx(input req_vec_t oh);
      req_idx_t idx;
      idx = '0;
      for (int i = 0; i < MAX_REQUESTERS; i++) begin
         if (oh[i]) idx = idx | req_idx_t'(i);
      end
      return idx;
   endfunction

   // Scans all MAX_REQUESTERS positions from ptr with 4-bit wrap. Unused upper
   // positions are always zero, so this equals a wrap at the real requester count.
   function automatic req_vec_t rotate_search(input req_vec_t valid, input req_idx_t ptr);
      req_vec_t grant;
      req_idx_t pos;
      logic     found;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQUESTERS; k++) begin
         pos = ptr + req_idx_t'(k);
         if (!found && valid[pos]) begin
            grant[pos] = 1'b1;
            found      = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// rr_arbiter
//   Single-port arbiter. Holds the round-robin pointer and produces a one-hot
//   (or zero) combinational grant from VALID. Grants are forced low in reset.
//   Build option SRAM_ARB_FIXED_PRIORITY_EN: lowest index always wins, no pointer.
//   Ports:
//     CLK    - clock
//     RESETN - asynchronous active-low reset
//     VALID  - per-requester request
//     GRANT  - one-hot grant or zero
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         CLK,
   input  logic         RESETN,
   input  logic [N-1:0] VALID,
   output logic [N-1:0] GRANT
);

   req_vec_t valid_ext;
   req_vec_t grant_ext;

   always_comb begin
      valid_ext        = '0;
      valid_ext[N-1:0] = VALID;
   end

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
   // Isolate the lowest set bit.
   assign grant_ext = valid_ext & (~valid_ext + req_vec_t'(1));

   logic unused_clk;
   assign unused_clk = CLK;
`else
   req_idx_t ptr_q;
   req_idx_t ptr_d;
   req_idx_t win_idx;

   assign grant_ext = rotate_search(valid_ext, ptr_q);
   assign win_idx   = onehot_to_idx(grant_ext);

   always_comb begin
      ptr_d = ptr_q;
      if (|grant_ext) begin
         ptr_d = (win_idx == req_idx_t'(N - 1)) ? '0 : win_idx + req_idx_t'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end
`endif

   logic unused_grant_hi;
   assign unused_grant_hi = ^grant_ext;

   assign GRANT = RESETN ? grant_ext[N-1:0] : '0;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one dual-port (1R/1W) byte-enabled SRAM between num_requesters masters.
//   Read and write ports are arbitrated independently; read data returns to the
//   owning requester one cycle after its grant.
//   Build option SRAM_ARB_FIXED_PRIORITY_EN: fixed lowest-index priority on both ports.
//   Ports:
//     CLK, RESETN                        - clock, async active-low reset
//     RD_VALID/RD_READY/RD_ADDR          - read request side
//     RSP_VALID/RSP_DATA                 - read response (one-hot valid, shared data)
//     WR_VALID/WR_READY/WR_ADDR/WR_DATA/WR_BE - write request side
//     SRAM_READ_ADDR/SRAM_OE/SRAM_DATA_OUT    - SRAM read port
//     SRAM_WRITE_ADDR/SRAM_DATA_IN/SRAM_BE/SRAM_WE - SRAM write port
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter  int address_width  = 22,
   parameter  int data_width     = 2,
   parameter  int num_requesters = 4,
   localparam int N = num_requesters,
   localparam int A = address_width,
   localparam int B = 1 << data_width,
   localparam int W = B * 8
) (
   input  logic           CLK,
   input  logic           RESETN,
   input  logic [N-1:0]   RD_VALID,
   output logic [N-1:0]   RD_READY,
   input  logic [N*A-1:0] RD_ADDR,
   output logic [N-1:0]   RSP_VALID,
   output logic [W-1:0]   RSP_DATA,
   input  logic [N-1:0]   WR_VALID,
   output logic [N-1:0]   WR_READY,
   input  logic [N*A-1:0] WR_ADDR,
   input  logic [N*W-1:0] WR_DATA,
   input  logic [N*B-1:0] WR_BE,
   output logic [A-1:0]   SRAM_READ_ADDR,
   output logic           SRAM_OE,
   input  logic [W-1:0]   SRAM_DATA_OUT,
   output logic [A-1:0]   SRAM_WRITE_ADDR,
   output logic [W-1:0]   SRAM_DATA_IN,
   output logic [B-1:0]   SRAM_BE,
   output logic           SRAM_WE
);

   logic [N-1:0] rd_gnt;
   logic [N-1:0] wr_gnt;
   logic [N-1:0] rsp_owner_q;
   logic [A-1:0] rd_addr_sel;
   logic [A-1:0] wr_addr_sel;
   logic [W-1:0] wr_data_sel;
   logic [B-1:0] wr_be_sel;
   logic [A-1:0] rd_addr_q;
   logic [A-1:0] wr_addr_q;

   rr_arbiter #(.N(N)) u_rd_arb (
      .CLK    (CLK),
      .RESETN (RESETN),
      .VALID  (RD_VALID),
      .GRANT  (rd_gnt)
   );

   rr_arbiter #(.N(N)) u_wr_arb (
      .CLK    (CLK),
      .RESETN (RESETN),
      .VALID  (WR_VALID),
      .GRANT  (wr_gnt)
   );

   // Grants are one-hot, so an unordered scan is a clean mux.
   always_comb begin
      rd_addr_sel = '0;
      wr_addr_sel = '0;
      wr_data_sel = '0;
      wr_be_sel   = '0;
      for (int i = 0; i < N; i++) begin
         if (rd_gnt[i]) rd_addr_sel = RD_ADDR[i*A +: A];
         if (wr_gnt[i]) begin
            wr_addr_sel = WR_ADDR[i*A +: A];
            wr_data_sel = WR_DATA[i*W +: W];
            wr_be_sel   = WR_BE[i*B +: B];
         end
      end
   end

   assign SRAM_OE = |rd_gnt;
   assign SRAM_WE = |wr_gnt;

   // The SRAM captures in the grant cycle, so the address is combinational on a
   // grant and falls back to the last granted word otherwise.
   assign SRAM_READ_ADDR  = SRAM_OE ? (rd_addr_sel >> data_width) : rd_addr_q;
   assign SRAM_WRITE_ADDR = SRAM_WE ? (wr_addr_sel >> data_width) : wr_addr_q;
   assign SRAM_DATA_IN    = wr_data_sel;
   assign SRAM_BE         = wr_be_sel;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         rsp_owner_q <= '0;
      end else begin
         rd_addr_q   <= SRAM_READ_ADDR;
         wr_addr_q   <= SRAM_WRITE_ADDR;
         rsp_owner_q <= rd_gnt;
      end
   end

   assign RD_READY  = rd_gnt;
   assign WR_READY  = wr_gnt;
   assign RSP_VALID = rsp_owner_q;
   assign RSP_DATA  = SRAM_DATA_OUT;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

   localparam int N  = 4;
   localparam int A  = 22;
   localparam int DW = 2;
   localparam int B  = 4;
   localparam int W  = 32;

   logic           CLK = 1'b0;
   logic           RESETN = 1'b0;
   logic [N-1:0]   RD_VALID = '0;
   logic [N-1:0]   RD_READY;
   logic [N*A-1:0] RD_ADDR = '0;
   logic [N-1:0]   RSP_VALID;
   logic [W-1:0]   RSP_DATA;
   logic [N-1:0]   WR_VALID = '0;
   logic [N-1:0]   WR_READY;
   logic [N*A-1:0] WR_ADDR = '0;
   logic [N*W-1:0] WR_DATA = '0;
   logic [N*B-1:0] WR_BE = '0;
   logic [A-1:0]   SRAM_READ_ADDR;
   logic           SRAM_OE;
   logic [W-1:0]   SRAM_DATA_OUT = '0;
   logic [A-1:0]   SRAM_WRITE_ADDR;
   logic [W-1:0]   SRAM_DATA_IN;
   logic [B-1:0]   SRAM_BE;
   logic           SRAM_WE;

   int n_total = 0;
   int n_pass  = 0;

   always #5 CLK = ~CLK;

   sram_arbiter #(
      .address_width  (A),
      .data_width     (DW),
      .num_requesters (N)
   ) dut (
      .CLK             (CLK),
      .RESETN          (RESETN),
      .RD_VALID        (RD_VALID),
      .RD_READY        (RD_READY),
      .RD_ADDR         (RD_ADDR),
      .RSP_VALID       (RSP_VALID),
      .RSP_DATA        (RSP_DATA),
      .WR_VALID        (WR_VALID),
      .WR_READY        (WR_READY),
      .WR_ADDR         (WR_ADDR),
      .WR_DATA         (WR_DATA),
      .WR_BE           (WR_BE),
      .SRAM_READ_ADDR  (SRAM_READ_ADDR),
      .SRAM_OE         (SRAM_OE),
      .SRAM_DATA_OUT   (SRAM_DATA_OUT),
      .SRAM_WRITE_ADDR (SRAM_WRITE_ADDR),
      .SRAM_DATA_IN    (SRAM_DATA_IN),
      .SRAM_BE         (SRAM_BE),
      .SRAM_WE         (SRAM_WE)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // SRAM macro stand-in: registered read, byte-enabled write, read-before-write.
   logic [W-1:0] sram_mem [int];
   always @(posedge CLK) begin
      logic [W-1:0] old_w;
      logic [W-1:0] new_w;
      old_w = sram_mem.exists(int'(SRAM_READ_ADDR)) ? sram_mem[int'(SRAM_READ_ADDR)] : '0;
      if (SRAM_OE) SRAM_DATA_OUT <= old_w;
      if (SRAM_WE) begin
         new_w = sram_mem.exists(int'(SRAM_WRITE_ADDR)) ? sram_mem[int'(SRAM_WRITE_ADDR)] : '0;
         for (int b = 0; b < B; b++)
            if (SRAM_BE[b]) new_w[b*8 +: 8] = SRAM_DATA_IN[b*8 +: 8];
         sram_mem[int'(SRAM_WRITE_ADDR)] = new_w;
      end
   end

   // ---------------- reference model ----------------
   logic [W-1:0] exp_mem [int];
   int           m_rd_ptr = 0;
   int           m_wr_ptr = 0;
   int           m_rsp_owner = -1;
   logic [W-1:0] m_rsp_data = '0;
   logic [A-1:0] m_rd_last = '0;
   logic [A-1:0] m_wr_last = '0;
   bit           m_rd_seen = 0;
   bit           m_wr_seen = 0;
   int           e_rd = -1;
   int           e_wr = -1;

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      int start;
      start = ptr;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
      start = 0;
`endif
      for (int k = 0; k < N; k++) begin
         int j;
         j = (start + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   // Compare process: outputs are stable mid-cycle.
   always @(negedge CLK) begin
      logic [A-1:0] wa;
      if (!RESETN) begin
         e_rd = -1;
         e_wr = -1;
      end else begin
         e_rd = pick(RD_VALID, m_rd_ptr);
         e_wr = pick(WR_VALID, m_wr_ptr);
      end
      chk("m_rd_ready", RD_READY, onehot(e_rd));
      chk("m_wr_ready", WR_READY, onehot(e_wr));
      chk("m_sram_oe", SRAM_OE, e_rd >= 0);
      chk("m_sram_we", SRAM_WE, e_wr >= 0);
      if (e_rd >= 0) begin
         wa = RD_ADDR[e_rd*A +: A] >> DW;
         chk("m_rd_addr", SRAM_READ_ADDR, wa);
      end else if (m_rd_seen && RESETN) begin
         chk("m_rd_addr_hold", SRAM_READ_ADDR, m_rd_last);
      end
      if (e_wr >= 0) begin
         wa = WR_ADDR[e_wr*A +: A] >> DW;
         chk("m_wr_addr", SRAM_WRITE_ADDR, wa);
         chk("m_wr_data", SRAM_DATA_IN, WR_DATA[e_wr*W +: W]);
         chk("m_wr_be", SRAM_BE, WR_BE[e_wr*B +: B]);
      end else if (m_wr_seen && RESETN) begin
         chk("m_wr_addr_hold", SRAM_WRITE_ADDR, m_wr_last);
      end
      chk("m_rsp_valid", RSP_VALID, onehot(m_rsp_owner));
      if (m_rsp_owner >= 0) chk("m_rsp_data", RSP_DATA, m_rsp_data);
   end

   always @(posedge CLK or negedge RESETN) begin
      logic [A-1:0] wa;
      logic [W-1:0] w;
      if (!RESETN) begin
         m_rd_ptr    = 0;
         m_wr_ptr    = 0;
         m_rsp_owner = -1;
         m_rd_seen   = 0;
         m_wr_seen   = 0;
      end else begin
         if (e_rd >= 0) begin
            wa          = RD_ADDR[e_rd*A +: A] >> DW;
            m_rsp_owner = e_rd;
            m_rsp_data  = exp_mem.exists(int'(wa)) ? exp_mem[int'(wa)] : '0;
            m_rd_ptr    = (e_rd + 1) % N;
            m_rd_last   = wa;
            m_rd_seen   = 1;
         end else begin
            m_rsp_owner = -1;
         end
         if (e_wr >= 0) begin
            wa = WR_ADDR[e_wr*A +: A] >> DW;
            w  = exp_mem.exists(int'(wa)) ? exp_mem[int'(wa)] : '0;
            for (int b = 0; b < B; b++)
               if (WR_BE[e_wr*B + b]) w[b*8 +: 8] = WR_DATA[e_wr*W + b*8 +: 8];
            exp_mem[int'(wa)] = w;
            m_wr_ptr  = (e_wr + 1) % N;
            m_wr_last = wa;
            m_wr_seen = 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
      #1;
   endtask

   task automatic clear();
      RD_VALID = '0;
      WR_VALID = '0;
   endtask

   task automatic set_rd(input int i, input logic [A-1:0] a);
      RD_VALID[i]      = 1'b1;
      RD_ADDR[i*A +: A] = a;
   endtask

   task automatic set_wr(input int i, input logic [A-1:0] a, input logic [W-1:0] d, input logic [B-1:0] be);
      WR_VALID[i]       = 1'b1;
      WR_ADDR[i*A +: A] = a;
      WR_DATA[i*W +: W] = d;
      WR_BE[i*B +: B]   = be;
   endtask

   logic [N-1:0] rr_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
   logic [N-1:0] prio_seq [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
   logic [N-1:0] prio_seq [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`endif
   logic [N-1:0] mix_rv [12] = '{4'b0110, 4'b1111, 4'b1001, 4'b0001, 4'b1100, 4'b0000,
                                 4'b1011, 4'b0100, 4'b1110, 4'b0011, 4'b1000, 4'b0101};
   logic [N-1:0] mix_wv [12] = '{4'b1001, 4'b0110, 4'b1111, 4'b0000, 4'b0011, 4'b1010,
                                 4'b0100, 4'b1101, 4'b0001, 4'b1110, 4'b0111, 4'b1000};

   initial begin
      // Reset: requests present but nothing may be granted.
      RESETN   = 1'b0;
      RD_VALID = '1;
      WR_VALID = '1;
      mid();
      chk("rst_rd_ready", RD_READY, 4'b0000);
      chk("rst_wr_ready", WR_READY, 4'b0000);
      chk("rst_oe_we", {SRAM_OE, SRAM_WE}, 2'b00);
      chk("rst_rsp_valid", RSP_VALID, 4'b0000);
      nxt();
      nxt();
      RESETN = 1'b1;
      clear();

      // Round-robin fairness under full read contention.
      for (int i = 0; i < N; i++) set_rd(i, 22'h100 + 22'(i * 4));
      for (int k = 0; k < 8; k++) begin
         mid();
         chk("rr_grant", RD_READY, rr_seq[k]);
         if (k > 0) chk("rr_rsp", RSP_VALID, rr_seq[k-1]);
         nxt();
      end
      clear();
      mid();
      chk("rr_rsp_last", RSP_VALID, 4'b1000);
      nxt();

      // Single read of a freshly written word.
      set_wr(0, 22'h10, 32'hDEADBEEF, 4'hF);
      mid();
      chk("sr_wr_addr", SRAM_WRITE_ADDR, 22'h4);
      nxt();
      clear();
      set_rd(2, 22'h10);
      mid();
      chk("sr_rd_addr", SRAM_READ_ADDR, 22'h4);
      chk("sr_rd_ready", RD_READY, 4'b0100);
      nxt();
      clear();
      mid();
      chk("sr_rsp_valid", RSP_VALID, 4'b0100);
      chk("sr_rsp_data", RSP_DATA, 32'hDEADBEEF);
      nxt();

      // Concurrent read/write to the same word: read sees the old word.
      set_wr(1, 22'h14, 32'hAABBCCDD, 4'hF);
      nxt();
      clear();
      set_wr(0, 22'h14, 32'h11223344, 4'b0011);
      set_rd(1, 22'h14);
      mid();
      chk("cc_grants", {WR_READY, RD_READY}, 8'b0001_0010);
      chk("cc_be", SRAM_BE, 4'b0011);
      nxt();
      clear();
      mid();
      chk("cc_old_word", RSP_DATA, 32'hAABBCCDD);
      nxt();
      set_rd(1, 22'h17);
      mid();
      chk("cc_low_bits_ignored", SRAM_READ_ADDR, 22'h5);
      nxt();
      clear();
      mid();
      chk("cc_merged_word", RSP_DATA, 32'hAABB3344);
      nxt();

      // All-zero byte enables: granted, WE pulses, memory unchanged.
      set_wr(3, 22'h14, 32'hFFFFFFFF, 4'b0000);
      mid();
      chk("be0_we", SRAM_WE, 1'b1);
      chk("be0_ready", WR_READY, 4'b1000);
      nxt();
      clear();
      set_rd(0, 22'h14);
      nxt();
      clear();
      mid();
      chk("be0_unchanged", RSP_DATA, 32'hAABB3344);
      nxt();

      // Reset in the cycle after a read grant drops the response.
      set_rd(3, 22'h10);
      mid();
      chk("rm_grant", RD_READY, 4'b1000);
      nxt();
      clear();
      RESETN = 1'b0;
      mid();
      chk("rm_rsp_in_reset", RSP_VALID, 4'b0000);
      nxt();
      RESETN = 1'b1;
      mid();
      chk("rm_rsp_after", RSP_VALID, 4'b0000);
      nxt();
      for (int i = 0; i < N; i++) begin
         set_rd(i, 22'h40 + 22'(i * 4));
         set_wr(i, 22'h80 + 22'(i * 4), 32'h5A5A0000 + 32'(i), 4'hF);
      end
      mid();
      chk("rm_first_rd", RD_READY, 4'b0001);
      chk("rm_first_wr", WR_READY, 4'b0001);
      nxt();
      clear();

      // Requesters 1 and 3 contending.
      RD_VALID = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         mid();
         chk("prio_grant", RD_READY, prio_seq[k]);
         nxt();
      end
      clear();

      // Mixed directed traffic, checked by the model only.
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < N; i++) begin
            RD_ADDR[i*A +: A] = 22'h80 + 22'((k + i) % 6 * 4) + 22'(i);
            WR_ADDR[i*A +: A] = 22'h80 + 22'((k * 3 + i) % 6 * 4);
            WR_DATA[i*W +: W] = 32'h01010101 * 32'(k + 1) ^ 32'(i << 28);
            WR_BE[i*B +: B]   = 4'(k + i);
         end
         RD_VALID = mix_rv[k];
         WR_VALID = mix_wv[k];
         nxt();
      end
      clear();
      nxt();
      nxt();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
